// File: rtl/irq_pkg.sv
// Shared definitions for the mips789 interrupt request controller.
// Holds the controller state encoding and the default source count.
package irq_pkg;

  localparam int IRQ_N_SRC_DEF = 8;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_SERV = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder used to pick the next interrupt candidate.
// Purely combinational; idx is 0 when no request is present.
module irq_prio_enc #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = ID_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctl.sv
// Interrupt request controller: edge-detects peripheral lines, masks them and
// drives the irq/iack handshake toward the pipeline control FSM.
module irq_ctl
  import irq_pkg::*;
#(
  parameter int N_SRC = IRQ_N_SRC_DEF,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             iack,
  output logic             irq,
  output logic [ID_W-1:0]  vec_id,
  output logic             in_service,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);

  irq_state_e       state;
  irq_state_e       state_n;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] mask_r;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  enc_idx;
  logic [ID_W-1:0]  vec_id_r;
  logic             enc_any;
  logic             cand_ld;
  logic             take_ack;
  logic             irq_r;
  logic             in_service_r;

  assign rise     = src & ~src_q;
  assign eligible = pending_r & mask_r;

  irq_prio_enc #(
    .N_SRC(N_SRC),
    .ID_W (ID_W)
  ) u_prio_enc (
    .req(eligible),
    .idx(enc_idx),
    .any(enc_any)
  );

  // An iack seen while idle is out of protocol, so it blocks a new request.
  always_comb begin
    state_n  = state;
    cand_ld  = 1'b0;
    take_ack = 1'b0;
    case (state)
      IRQ_IDLE: begin
        if (enc_any && !iack) begin
          state_n = IRQ_REQ;
          cand_ld = 1'b1;
        end
      end
      IRQ_REQ: begin
        if (iack) begin
          state_n  = IRQ_SERV;
          take_ack = 1'b1;
        end
      end
      IRQ_SERV: begin
        if (!iack) begin
          state_n = IRQ_IDLE;
        end
      end
      default: state_n = IRQ_IDLE;
    endcase
  end

  assign ack_clr = take_ack ? (N_SRC'(1) << cand) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IRQ_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // OR-ing rise after the clear lets a new edge on the serviced source survive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q        <= '0;
      pending_r    <= '0;
      mask_r       <= '0;
      cand         <= '0;
      vec_id_r     <= '0;
      irq_r        <= 1'b0;
      in_service_r <= 1'b0;
    end else begin
      src_q     <= src;
      pending_r <= (pending_r & ~ack_clr) | rise;
      if (mask_we) begin
        mask_r <= mask_wdata;
      end
      if (cand_ld) begin
        cand <= enc_idx;
      end
      if (take_ack) begin
        vec_id_r <= cand;
      end
      irq_r        <= (state_n == IRQ_REQ);
      in_service_r <= (state_n == IRQ_SERV);
    end
  end

  assign irq        = irq_r;
  assign vec_id     = vec_id_r;
  assign in_service = in_service_r;
  assign pending    = pending_r;
  assign mask       = mask_r;

endmodule

// File: tb/tb_irq_ctl.sv
// Self-checking bench for irq_ctl: scenario tasks plus a scoreboard of the
// vector ids expected at each handler entry.
module tb_irq_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] src = '0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = '0;
  logic       iack = 1'b0;
  logic       irq;
  logic [2:0] vec_id;
  logic       in_service;
  logic [7:0] pending;
  logic [7:0] mask;

  int assertions = 0;
  int failures = 0;
  int exp_q[$];
  logic svc_prev = 1'b0;

  irq_ctl #(.N_SRC(8), .ID_W(3)) dut (
    .clk(clk), .rst(rst), .src(src), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .iack(iack), .irq(irq), .vec_id(vec_id), .in_service(in_service),
    .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  // Scoreboard: each handler entry must match the oldest expected vector id.
  always @(negedge clk) begin
    if (rst && in_service && !svc_prev) begin
      assertions++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_unexpected: got vec_id %0d, expected no service", vec_id);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (vec_id !== 3'(e)) begin
          failures++;
          $display("[TB] FAIL sb_vec_id: got %0d expected %0d", vec_id, e);
        end
      end
    end
    svc_prev = in_service;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_mask(input logic [7:0] v);
    mask_we = 1'b1;
    mask_wdata = v;
    step(1);
    mask_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    src = v;
    step(1);
    src = '0;
  endtask

  task automatic wait_irq(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= max; i++) begin
      if (irq === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic ack_cycle(input int hold);
    iack = 1'b1;
    step(hold);
    iack = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    assertions++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL rst_irq: got %b expected 0", irq); end
    assertions++; if (vec_id !== 3'd0) begin failures++; $display("[TB] FAIL rst_vec_id: got %0d expected 0", vec_id); end
    assertions++; if (in_service !== 1'b0) begin failures++; $display("[TB] FAIL rst_in_service: got %b expected 0", in_service); end
    assertions++; if (pending !== 8'h00) begin failures++; $display("[TB] FAIL rst_pending: got %h expected 00", pending); end
    assertions++; if (mask !== 8'h00) begin failures++; $display("[TB] FAIL rst_mask: got %h expected 00", mask); end
  endtask

  task automatic test_basic();
    write_mask(8'hFF);
    assertions++; if (mask !== 8'hFF) begin failures++; $display("[TB] FAIL basic_mask: got %h expected ff", mask); end
    pulse(8'h08);
    assertions++; if (pending !== 8'h08) begin failures++; $display("[TB] FAIL basic_pending: got %h expected 08", pending); end
    assertions++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL basic_irq_early: got %b expected 0", irq); end
    step(1);
    assertions++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL basic_irq: got %b expected 1", irq); end
    exp_q.push_back(3);
    step(3);
    assertions++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL basic_irq_hold: got %b expected 1", irq); end
    iack = 1'b1;
    step(1);
    assertions++; if (in_service !== 1'b1) begin failures++; $display("[TB] FAIL basic_in_service: got %b expected 1", in_service); end
    assertions++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL basic_irq_ack: got %b expected 0", irq); end
    assertions++; if (pending !== 8'h00) begin failures++; $display("[TB] FAIL basic_pending_clr: got %h expected 00", pending); end
    step(9);
    iack = 1'b0;
    step(1);
    assertions++; if (in_service !== 1'b0) begin failures++; $display("[TB] FAIL basic_return: got %b expected 0", in_service); end
    step(2);
    assertions++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL basic_idle_irq: got %b expected 0", irq); end
  endtask

  task automatic test_priority();
    bit ok;
    pulse(8'h22);
    step(1);
    assertions++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL prio_irq: got %b expected 1", irq); end
    exp_q.push_back(1);
    exp_q.push_back(5);
    iack = 1'b1;
    step(1);
    assertions++; if (pending !== 8'h20) begin failures++; $display("[TB] FAIL prio_pending: got %h expected 20", pending); end
    step(2);
    iack = 1'b0;
    step(1);
    wait_irq(2, ok);
    assertions++; if (!ok) begin failures++; $display("[TB] FAIL prio_reassert: got timeout expected irq within 2 cycles"); end
    ack_cycle(2);
    assertions++; if (pending !== 8'h00) begin failures++; $display("[TB] FAIL prio_pending_end: got %h expected 00", pending); end
  endtask

  task automatic test_masking();
    write_mask(8'h00);
    pulse(8'h04);
    step(1);
    pulse(8'h04);
    step(2);
    assertions++; if (pending !== 8'h04) begin failures++; $display("[TB] FAIL mask_pending: got %h expected 04", pending); end
    assertions++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL mask_irq_off: got %b expected 0", irq); end
    write_mask(8'h04);
    assertions++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL mask_irq_early: got %b expected 0", irq); end
    step(1);
    assertions++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL mask_irq_on: got %b expected 1", irq); end
    exp_q.push_back(2);
    ack_cycle(2);
    step(2);
    assertions++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL mask_collapse: got %b expected 0", irq); end
  endtask

  task automatic test_collision();
    bit ok;
    write_mask(8'hFF);
    pulse(8'h10);
    step(1);
    exp_q.push_back(4);
    src = 8'h10;
    iack = 1'b1;
    step(1);
    src = '0;
    assertions++; if (pending !== 8'h10) begin failures++; $display("[TB] FAIL coll_pending: got %h expected 10", pending); end
    assertions++; if (in_service !== 1'b1) begin failures++; $display("[TB] FAIL coll_in_service: got %b expected 1", in_service); end
    step(2);
    iack = 1'b0;
    step(1);
    exp_q.push_back(4);
    wait_irq(3, ok);
    assertions++; if (!ok) begin failures++; $display("[TB] FAIL coll_second_req: got timeout expected irq"); end
    ack_cycle(2);
    assertions++; if (pending !== 8'h00) begin failures++; $display("[TB] FAIL coll_pending_end: got %h expected 00", pending); end
  endtask

  task automatic test_frozen();
    pulse(8'h01);
    step(1);
    exp_q.push_back(0);
    write_mask(8'h00);
    assertions++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL frozen_irq: got %b expected 1", irq); end
    assertions++; if (mask !== 8'h00) begin failures++; $display("[TB] FAIL frozen_mask: got %h expected 00", mask); end
    iack = 1'b1;
    step(1);
    assertions++; if (in_service !== 1'b1) begin failures++; $display("[TB] FAIL frozen_in_service: got %b expected 1", in_service); end
    iack = 1'b0;
    step(3);
    assertions++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL frozen_idle: got %b expected 0", irq); end
  endtask

  task automatic test_reset_spurious();
    write_mask(8'hFF);
    pulse(8'h40);
    step(1);
    exp_q.push_back(6);
    iack = 1'b1;
    step(1);
    pulse(8'h02);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    assertions++; if (in_service !== 1'b0) begin failures++; $display("[TB] FAIL midrst_in_service: got %b expected 0", in_service); end
    assertions++; if (vec_id !== 3'd0) begin failures++; $display("[TB] FAIL midrst_vec_id: got %0d expected 0", vec_id); end
    assertions++; if (pending !== 8'h00) begin failures++; $display("[TB] FAIL midrst_pending: got %h expected 00", pending); end
    assertions++; if (mask !== 8'h00) begin failures++; $display("[TB] FAIL midrst_mask: got %h expected 00", mask); end
    iack = 1'b0;
    step(1);
    write_mask(8'hFF);
    iack = 1'b1;
    pulse(8'h80);
    step(3);
    assertions++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL spur_irq: got %b expected 0", irq); end
    assertions++; if (pending !== 8'h80) begin failures++; $display("[TB] FAIL spur_pending: got %h expected 80", pending); end
    iack = 1'b0;
    step(1);
    assertions++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL spur_irq_after: got %b expected 1", irq); end
    exp_q.push_back(7);
    ack_cycle(2);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_masking();
    test_collision();
    test_frozen();
    test_reset_spurious();
    step(3);
    assertions++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover: got %0d unserviced expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
